piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out framer that sits directly upstream of the 4-bit serial-in/parallel-out register.
- Accepts parallel words over a valid/ready handshake and drives them MSB-first onto the downstream register's serial data input, one bit per clock.
- After the last data bit of a word, the downstream register holds the word in natural order: bit 3 = MSB.
- A one-word holding buffer allows back-to-back words to stream with no idle cycles between them.

Parameters:
- WIDTH, 4, data word width in bits. Must be ≥2.
- IDLE_LEVEL, 1'b0, value driven on dout when no bit is being transmitted.

Ports:
- clock  input  1  rising-edge system clock.
- clear  input  1  asynchronous, active-low reset. Low = reset.
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit stream, MSB first. Feeds the downstream register's din.
- dout_en  output  1  dout carries a valid bit this cycle.
- word_done  output  1  one-cycle pulse, high while the last bit of a word is on dout.
- busy  output  1  a word is shifting or a word is held in the buffer.

Behaviour:
- Reset (clear low, asynchronous; release is synchronous to clock):
  - dout = IDLE_LEVEL; dout_en = 0; word_done = 0; busy = 0.
  - Holding buffer empty; bit counter = 0; state = IDLE.
  - load_ready = 1 in the first cycle after release.
- All outputs are registered. Exception: load_ready = !hold_full, decoded from a register.
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
- States:
  - IDLE: dout = IDLE_LEVEL, dout_en = 0.
    - Accept edge: dout <= W[WIDTH-1]; dout_en <= 1; shift register <= W << 1; remaining count <= WIDTH-1; state -> SHIFT.
    - Latency: first bit appears one cycle after acceptance.
  - SHIFT:
    - Each edge with remaining > 0: dout <= sreg[WIDTH-1]; sreg <<= 1; remaining--.
    - word_done is high on the cycle where dout presents bit 0 (remaining == 0).
    - Last-bit edge (remaining == 0) — the next word starts immediately, with no gap, in priority order:
      - If the buffer is full: load the buffered word exactly as in the IDLE accept, and empty the buffer.
      - Else, if an accept occurs on this same edge: load load_data directly (bypass). The buffer stays empty.
      - Else: dout <= IDLE_LEVEL; dout_en <= 0; state -> IDLE.
  - Accepting while in SHIFT (not the last-bit edge): the word goes into the buffer, and load_ready drops next cycle.
  - Buffer-full edge: the buffer drains into the shifter while load_ready = 0, so no accept can coincide with the drain.
- busy = (state == SHIFT) || hold_full.
- Throughput: one word per WIDTH cycles, sustained.
- load_data is ignored while load_valid = 0. A load_valid pulse while load_ready = 0 is dropped; no error flag.
- X/Z on load_data when load_valid = 0 must not propagate to dout.
- Reset mid-word: asynchronous abort. The partially sent word and the buffered word are discarded. dout returns to IDLE_LEVEL immediately.
- Downstream contract: the SIPO register captures dout on each rising edge. On the edge after word_done, its Q equals the transmitted word (WIDTH = 4).

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit: XOR of all WIDTH data bits, via a PARITY state entered at remaining == 0.
  - dout_en stays 1 during the parity bit.
  - word_done moves to the parity cycle.
  - Words are WIDTH+1 cycles apart; next-word and bypass rules apply on the parity edge.
- Undefined: no parity state, no parity logic; behaviour exactly as above.

Test Plan:
- Reset/idle: hold clear low 3 cycles with load_valid = 1 and load_data = 4'hF → dout = 0, dout_en = 0, load_ready = 0 held? No — load_ready = 1 after release; nothing accepted during reset; busy = 0.
- Single word: accept 4'b1011 → dout = 1,0,1,1 on cycles 1–4 after accept; dout_en high exactly those 4 cycles; word_done on cycle 4. Downstream Q = 4'b1011 one edge later.
- Back-to-back: accept 4'hA; while shifting, accept 4'h5 (buffered; load_ready low next cycle) → dout = 1010 then 0101 with no gap; dout_en high for 8 consecutive cycles; 2 word_done pulses.
- Bypass: offer 4'h6 exactly on the last-bit edge of 4'h9 with the buffer empty → 0110 follows 1001 with no gap; load_ready never drops.
- Reset mid-word: assert clear after 2 bits of 4'hC → dout = IDLE_LEVEL and dout_en = 0 asynchronously. After release, 4'h3 transmits correctly.
- PISO_PARITY_EN: send 4'b0111 → 0,1,1,1, then parity 1; 5-cycle dout_en; word_done on the parity cycle.

Source files
------------

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial framer with a one-word holding buffer for gap-free streaming.
// Optional macro PISO_PARITY_EN appends an even-parity bit after each word.
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_en,
  output logic             word_done,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Handshake: a word transfers on a rising edge where load_valid && load_ready;
  // load_data is ignored otherwise, and a valid offered while not ready is dropped.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic [CW-1:0]    r_rem, w_rem_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_dout_en, w_dout_en_nxt;
  logic             r_word_done, w_word_done_nxt;
  logic             w_accept, w_end, w_start, w_hold_wr;
  logic [WIDTH-1:0] w_src;
`ifdef PISO_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_accept = load_valid & ~r_hold_full;
`ifdef PISO_PARITY_EN
  assign w_end = (r_state == ST_PARITY);
`else
  assign w_end = (r_state == ST_SHIFT) && (r_rem == '0);
`endif
  // A new word starts from IDLE, or back-to-back on the end edge (buffer first, else bypass).
  assign w_start   = ((r_state == ST_IDLE) & w_accept) | (w_end & (r_hold_full | w_accept));
  assign w_hold_wr = w_accept & (r_state != ST_IDLE) & ~w_end;
  assign w_src     = r_hold_full ? r_hold : load_data;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state     <= ST_IDLE;
      r_sreg      <= '0;
      r_hold      <= '0;
      r_rem       <= '0;
      r_hold_full <= 1'b0;
      r_dout      <= IDLE_LEVEL;
      r_dout_en   <= 1'b0;
      r_word_done <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_hold      <= w_hold_nxt;
      r_rem       <= w_rem_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_dout      <= w_dout_nxt;
      r_dout_en   <= w_dout_en_nxt;
      r_word_done <= w_word_done_nxt;
`ifdef PISO_PARITY_EN
      r_par       <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (r_rem == '0) begin
`ifdef PISO_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = w_start ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
      ST_PARITY: w_state_nxt = w_start ? ST_SHIFT : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sreg_nxt      = r_sreg;
    w_rem_nxt       = r_rem;
    w_dout_nxt      = IDLE_LEVEL;
    w_dout_en_nxt   = 1'b0;
    w_word_done_nxt = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_nxt       = r_par;
`endif
    if (w_start) begin
      w_dout_nxt    = w_src[WIDTH-1];
      w_dout_en_nxt = 1'b1;
      w_sreg_nxt    = {w_src[WIDTH-2:0], 1'b0};
      w_rem_nxt     = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
      w_par_nxt     = ^w_src;
`endif
    end else if ((r_state == ST_SHIFT) && (r_rem != '0)) begin
      w_dout_nxt    = r_sreg[WIDTH-1];
      w_dout_en_nxt = 1'b1;
      w_sreg_nxt    = {r_sreg[WIDTH-2:0], 1'b0};
      w_rem_nxt     = r_rem - CW'(1);
`ifndef PISO_PARITY_EN
      w_word_done_nxt = (r_rem == CW'(1));
`endif
    end
`ifdef PISO_PARITY_EN
    else if (r_state == ST_SHIFT) begin
      w_dout_nxt      = r_par;
      w_dout_en_nxt   = 1'b1;
      w_word_done_nxt = 1'b1;
    end
`endif
  end

  // The buffer drains on the end edge; it can never refill then because load_ready is low.
  always_comb begin
    w_hold_nxt      = w_hold_wr ? load_data : r_hold;
    w_hold_full_nxt = w_hold_wr | (r_hold_full & ~w_end);
  end

  assign load_ready  = ~r_hold_full;
  assign dout        = r_dout;
  assign dout_en     = r_dout_en;
  assign word_done   = r_word_done;
  assign busy        = (r_state != ST_IDLE) | r_hold_full;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer against a bit-queue reference model and a downstream SIPO model.
module tb_piso_serializer;
  localparam int   W    = 4;
  localparam logic IDLE = 1'b0;
`ifdef PISO_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, dout, dout_en, word_done, busy;
  logic [1:0]   dbg_state;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
    .clock       (clock),
    .clear       (clear),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .dout        (dout),
    .dout_en     (dout_en),
    .word_done   (word_done),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: every cycle still to be shown on dout, as {done, bit}.
  logic [1:0]   line_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sipo_q = '0;
  logic [W-1:0] sipo_word = '0;
  logic         sipo_chk = 1'b0;
  logic         exp_dout = IDLE;
  logic         exp_en = 1'b0;
  logic         exp_done = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) line_q.push_back({(i == 0) && (F == W), w[i]});
    if (F > W) line_q.push_back({1'b1, ^w});
    exp_q.push_back(w);
  endtask

  task automatic check_outputs();
    check("dout", dout, exp_dout);
    check("dout_en", dout_en, exp_en);
    check("word_done", word_done, exp_done);
    check("busy", busy, exp_en);
  endtask

  // Called at a falling edge: drives inputs, steps one clock, checks outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    logic       rdy;
    logic       pre;
    logic [1:0] e;
    load_valid = v;
    load_data  = v ? d : W'($urandom);
    rdy = (line_q.size() < F);
    check("load_ready", load_ready, rdy);
    pre = dout;
    @(posedge clock);
    sipo_q = {sipo_q[W-2:0], pre};
`ifndef PISO_PARITY_EN
    if (sipo_chk) check("sipo_q", sipo_q, sipo_word);
`endif
    sipo_chk = 1'b0;
    if (v && rdy) push_word(d);
    if (line_q.size() > 0) begin
      e = line_q.pop_front();
      exp_dout = e[0];
      exp_en   = 1'b1;
      exp_done = e[1];
      if (e[1]) begin
        sipo_word = exp_q.pop_front();
        sipo_chk  = 1'b1;
      end
    end else begin
      exp_dout = IDLE;
      exp_en   = 1'b0;
      exp_done = 1'b0;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic model_clear();
    line_q.delete();
    exp_q.delete();
    sipo_chk = 1'b0;
    exp_dout = IDLE;
    exp_en   = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic do_reset(input int n);
    clear = 1'b0;
    load_valid = 1'b1;
    load_data  = '1;
    model_clear();
    repeat (n) begin
      @(negedge clock);
      check_outputs();
    end
    load_valid = 1'b0;
    clear = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0);
  endtask

  initial begin
    do_reset(3);
    idle(2);

    // single word
    cycle(1'b1, 4'b1011);
    idle(F + 2);

    // back-to-back through the buffer
    cycle(1'b1, 4'hA);
    cycle(1'b0, '0);
    cycle(1'b1, 4'h5);
    idle(2 * F + 2);

    // bypass on the end edge
    cycle(1'b1, 4'h9);
    idle(F - 1);
    cycle(1'b1, 4'h6);
    idle(F + 2);

    // asynchronous abort after two bits
    cycle(1'b1, 4'hC);
    cycle(1'b0, '0);
    #2 clear = 1'b0;
    #1;
    model_clear();
    check("abort_dout", dout, IDLE);
    check("abort_en", dout_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(negedge clock);
    clear = 1'b1;
    cycle(1'b1, 4'h3);
    idle(F + 2);

    // random traffic
    for (int k = 0; k < 400; k++) cycle($urandom_range(0, 3) != 0, W'($urandom));
    idle(2 * F + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
